// File: rtl/fp_alu_pkg.sv
// Shared types and constants for the host side of the byte-serial FP32 add/sub ALU link.
package fp_alu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SEND,
        ST_WAIT_DONE,
        ST_RECV,
        ST_RESP,
        ST_FAULT
    } state_t;

    localparam int OPERAND_BYTES = 4;
    localparam int SEND_BYTES    = 8;
    localparam int RESULT_BYTES  = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Byte idx of the outbound stream: A low byte first, then B low byte first.
    function automatic logic [7:0] send_byte(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [2:0]  idx);
        logic [2*OPERAND_BYTES*8-1:0] pair;
        pair = {b, a};
        return pair[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/fp_alu_host.sv
// Host initiator: takes a wide add/sub request, serialises it to the FP32 ALU,
// collects the 4 result bytes and returns them on a one-cycle response strobe.
module fp_alu_host
    import fp_alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_op,
    output logic        resp_valid,
    output logic [31:0] resp_result,
    output logic        resp_error,
    output logic        alu_start,
    output logic [7:0]  alu_in,
    output logic        alu_opcode,
    input  logic        alu_done,
    input  logic [7:0]  alu_out
);

    // Request handshake: a transfer happens on a rising edge where req_valid
    // and req_ready are both high; req_ready is high only in IDLE, so a request
    // presented elsewhere simply waits and is never dropped.

    localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  T_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]     SEND_LAST = 3'(SEND_BYTES - 1);
    localparam logic [1:0]     RECV_LAST = 2'(RESULT_BYTES - 1);

    state_t         state_q, state_d;
    logic [31:0]    a_q, a_d;
    logic [31:0]    b_q, b_d;
    logic [31:0]    rbuf_q, rbuf_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [1:0]     rcnt_q, rcnt_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;

    logic           req_ready_d;
    logic           resp_valid_d;
    logic [31:0]    resp_result_d;
    logic           resp_error_d;
    logic           alu_start_d;
    logic [7:0]     alu_in_d;
    logic           alu_opcode_d;

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        rbuf_d        = rbuf_q;
        cnt_d         = cnt_q;
        rcnt_d        = rcnt_q;
        tcnt_d        = tcnt_q;
        resp_valid_d  = 1'b0;
        resp_result_d = resp_result;
        resp_error_d  = resp_error;
        alu_start_d   = 1'b0;
        alu_in_d      = alu_in;
        alu_opcode_d  = alu_opcode;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    a_d          = req_a;
                    b_d          = req_b;
                    alu_opcode_d = req_op;
                    alu_start_d  = 1'b1;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                alu_in_d = send_byte(a_q, b_q, 3'd0);
                cnt_d    = 3'd0;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (cnt_q == SEND_LAST) begin
                    alu_in_d = 8'h00;
                    tcnt_d   = '0;
                    state_d  = ST_WAIT_DONE;
                end else begin
                    cnt_d    = cnt_q + 3'd1;
                    alu_in_d = send_byte(a_q, b_q, cnt_q + 3'd1);
                end
            end
            ST_WAIT_DONE: begin
                if (alu_done) begin
                    rcnt_d  = 2'd0;
                    state_d = ST_RECV;
                end else if (tcnt_q == T_LAST) begin
                    resp_valid_d  = 1'b1;
                    resp_error_d  = 1'b1;
                    resp_result_d = 32'h0;
                    state_d       = ST_FAULT;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_RECV: begin
                rbuf_d[{rcnt_q, 3'b000} +: 8] = alu_out;
                if (rcnt_q == RECV_LAST) begin
                    resp_valid_d  = 1'b1;
                    resp_error_d  = 1'b0;
                    resp_result_d = {alu_out, rbuf_q[23:0]};
                    state_d       = ST_RESP;
                end else begin
                    rcnt_d = rcnt_q + 2'd1;
                end
            end
            ST_RESP: begin
                alu_opcode_d = 1'b0;
                state_d      = ST_IDLE;
            end
            // The ALU may still be mid-frame, so the link stays dead until rst_n.
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            rbuf_q      <= 32'h0;
            cnt_q       <= 3'd0;
            rcnt_q      <= 2'd0;
            tcnt_q      <= '0;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_result <= 32'h0;
            resp_error  <= 1'b0;
            alu_start   <= 1'b0;
            alu_in      <= 8'h00;
            alu_opcode  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rbuf_q      <= rbuf_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            tcnt_q      <= tcnt_d;
            req_ready   <= req_ready_d;
            resp_valid  <= resp_valid_d;
            resp_result <= resp_result_d;
            resp_error  <= resp_error_d;
            alu_start   <= alu_start_d;
            alu_in      <= alu_in_d;
            alu_opcode  <= alu_opcode_d;
        end
    end

endmodule

// File: tb/tb_fp_alu_host.sv
// Bench for fp_alu_host paired with a behavioural byte-serial FP32 ALU model.
module tb_fp_alu_host;

    localparam int TIMEOUT_CYCLES = 16;
    localparam int NOM_LAT        = 17;
    localparam int FAULT_LAT      = 9 + TIMEOUT_CYCLES;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = 32'h0;
    logic [31:0] req_b = 32'h0;
    logic        req_op = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_result;
    logic        resp_error;
    logic        alu_start;
    logic [7:0]  alu_in;
    logic        alu_opcode;
    logic        alu_done;
    logic [7:0]  alu_out;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [32:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];
    logic        in_txn = 1'b0;
    logic        mon_op = 1'b0;
    logic        prev_start = 1'b0;

    logic        alu_enable = 1'b1;
    logic        spur_done = 1'b0;
    logic        m_busy;
    int          m_t;
    logic [63:0] m_rx;
    logic [31:0] m_res;
    logic        m_done;

    fp_alu_host #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_result (resp_result),
        .resp_error  (resp_error),
        .alu_start   (alu_start),
        .alu_in      (alu_in),
        .alu_opcode  (alu_opcode),
        .alu_done    (alu_done),
        .alu_out     (alu_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- ALU model ----------------
    // Known sums/differences for the directed vectors.
    function automatic logic [31:0] alu_table(input logic [31:0] a, input logic [31:0] b,
                                              input logic op);
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        if (!op && a == 32'h3F80_0000 && b == 32'h4000_0000) r = 32'h4040_0000;
        if (!op && a == 32'h3F80_0000 && b == 32'h3F80_0000) r = 32'h4000_0000;
        if ( op && a == 32'h4040_0000 && b == 32'h3F80_0000) r = 32'h4000_0000;
        if ( op && a == 32'h4000_0000 && b == 32'h3F00_0000) r = 32'h3FC0_0000;
        return r;
    endfunction

    // Start sampled at edge E1; bytes taken E2..E9, done visible after E12,
    // result bytes driven after E13..E16.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_t     <= 0;
            m_rx    <= 64'h0;
            m_res   <= 32'h0;
            m_done  <= 1'b0;
            alu_out <= 8'h00;
        end else if (!m_busy) begin
            if (alu_start && alu_enable) begin
                m_busy <= 1'b1;
                m_t    <= 1;
            end
        end else begin
            m_t <= m_t + 1;
            if (m_t >= 1 && m_t <= 8) m_rx[(m_t-1)*8 +: 8] <= alu_in;
            if (m_t == 9) m_res <= alu_table(m_rx[31:0], m_rx[63:32], alu_opcode);
            m_done <= (m_t == 11);
            if (m_t >= 12 && m_t <= 15) alu_out <= m_res[(m_t-12)*8 +: 8];
            else alu_out <= 8'h00;
            if (m_t == 16) m_busy <= 1'b0;
        end
    end

    assign alu_done = m_done | spur_done;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard / protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [32:0] e;
        int l;
        int a;
        if (rst_n) begin
            if (in_txn) begin
                check("opcode_hold", alu_opcode, mon_op);
                check("ready_low", req_ready, 1'b0);
            end
            if (alu_start) check("start_single", prev_start, 1'b0);
            if (resp_valid) begin
                check("resp_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    a = acc_q.pop_front();
                    check("resp", {resp_error, resp_result}, e);
                    check("latency", cyc - a, l);
                end
                in_txn = 1'b0;
            end
            if (req_valid && req_ready) begin
                in_txn = 1'b1;
                mon_op = req_op;
                acc_q.push_back(cyc + 1);
            end
        end
        prev_start = alu_start;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_outputs",
              {req_ready, resp_valid, resp_result, resp_error, alu_start, alu_in, alu_opcode},
              64'h0);
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        in_txn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_ready_after_reset();
        @(posedge clk);
        @(negedge clk);
        check("post_reset_ready", req_ready, 1'b1);
    endtask

    // Leaves req_valid high so a following call forms a back-to-back request.
    task automatic send_req(input logic [31:0] a, input logic [31:0] b, input logic op,
                            input logic err, input logic [31:0] res, input int lat);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        exp_q.push_back({err, res});
        lat_q.push_back(lat);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        check("accept", ok, 1'b1);
    endtask

    task automatic drop_req();
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        if (exp_q.size() != 0) begin
            exp_q.delete();
            lat_q.delete();
            acc_q.delete();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #2;
        do_reset();
        check_ready_after_reset();

        // 1.0 + 2.0
        send_req(32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h4040_0000, NOM_LAT);
        drop_req();
        wait_drain(60);
        check("send_bytes", m_rx, {32'h4000_0000, 32'h3F80_0000});
        repeat (3) @(negedge clk);
        check("result_hold", {resp_valid, resp_result}, {1'b0, 32'h4040_0000});
        check("idle_ready", req_ready, 1'b1);

        // 3.0 - 1.0
        send_req(32'h4040_0000, 32'h3F80_0000, 1'b1, 1'b0, 32'h4000_0000, NOM_LAT);
        drop_req();
        wait_drain(60);
        check("sub_bytes", m_rx, {32'h3F80_0000, 32'h4040_0000});

        // Back-to-back with valid held: 1.0 + 1.0 then 2.0 - 0.5
        send_req(32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 32'h4000_0000, NOM_LAT);
        send_req(32'h4000_0000, 32'h3F00_0000, 1'b1, 1'b0, 32'h3FC0_0000, NOM_LAT);
        drop_req();
        wait_drain(80);

        // Spurious done while IDLE, then during SEND
        @(posedge clk); #1; spur_done = 1'b1;
        @(posedge clk); #1; spur_done = 1'b0;
        repeat (3) @(negedge clk);
        check("spur_idle_ready", req_ready, 1'b1);
        check("spur_idle_noresp", resp_valid, 1'b0);
        send_req(32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h4040_0000, NOM_LAT);
        drop_req();
        repeat (2) @(posedge clk);
        #1; spur_done = 1'b1;
        @(posedge clk); #1; spur_done = 1'b0;
        wait_drain(60);

        // Reset while SEND holds cnt=3
        send_req(32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h4040_0000, NOM_LAT);
        drop_req();
        repeat (4) @(posedge clk);
        #2;
        do_reset();
        repeat (2) @(negedge clk);
        check("reset_noresp", resp_valid, 1'b0);
        check("reset_ready", req_ready, 1'b1);
        send_req(32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h4040_0000, NOM_LAT);
        drop_req();
        wait_drain(60);

        // Dead ALU: timeout fault, then stall until reset
        alu_enable = 1'b0;
        send_req(32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1, 32'h0, FAULT_LAT);
        drop_req();
        wait_drain(80);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_a     = 32'h3F80_0000;
        req_b     = 32'h3F80_0000;
        req_op    = 1'b0;
        repeat (5) @(negedge clk);
        check("fault_stall_ready", req_ready, 1'b0);
        check("fault_stall_noresp", resp_valid, 1'b0);
        req_valid = 1'b0;
        do_reset();
        alu_enable = 1'b1;
        check_ready_after_reset();
        send_req(32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 32'h4000_0000, NOM_LAT);
        drop_req();
        wait_drain(60);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_alu_host.md
Name: fp_alu_host

Overview:
Host-side initiator for the byte-serial FP32 add/sub ALU link. It accepts a 32-bit operand pair plus opcode over a valid/ready request port. It then drives the ALU's start/in/opcode pins, waits for the ALU's done pulse, collects the 4 result bytes from the ALU's out bus and presents the assembled result on a one-cycle response strobe. It sits between a wide-bus controller and the ALU core and shares clk/rst_n with the ALU.

Parameters:
TIMEOUT_CYCLES, 16, max cycles spent in WAIT_DONE before declaring a link fault (must be >= 5).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request (IDLE only).
req_a  input  32  operand A, IEEE-754 single.
req_b  input  32  operand B, IEEE-754 single.
req_op  input  1  0 = A+B, 1 = A-B.
resp_valid  output  1  one-cycle strobe: resp_result/resp_error valid.
resp_result  output  32  assembled ALU result.
resp_error  output  1  1 = timeout fault (resp_result = 0).
alu_start  output  1  to ALU start.
alu_in  output  8  to ALU in.
alu_opcode  output  1  to ALU opcode.
alu_done  input  1  from ALU done.
alu_out  input  8  from ALU out.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: all outputs 0 except req_ready (0 during reset, 1 in the first IDLE cycle after release). State goes to IDLE. Counters and the fault flag clear. Reset mid-transaction aborts without a response; the ALU resets on the same rst_n.
- All outputs are registered.
- States: IDLE, START, SEND, WAIT_DONE, RECV, RESP, FAULT.
- IDLE: req_ready=1. On req_valid&&req_ready at edge E0:
  - latch a, b, op;
  - alu_opcode <= op;
  - alu_start <= 1;
  - go to START.
- START (1 cycle, alu_start=1): at E1 set alu_start <= 0, alu_in <= A[7:0], cnt <= 0, go to SEND.
- SEND: alu_in carries byte cnt of the sequence A[7:0], A[15:8], A[23:16], A[31:24], B[7:0] .. B[31:24] (LSB byte first, A before B). Each edge advances cnt and loads the next byte. At the edge that ends cnt=7 (E9), alu_in <= 0, tcnt <= 0, go to WAIT_DONE.
- alu_opcode holds the latched op from E0 until return to IDLE. The ALU samples it combinationally during its execute cycle.
- WAIT_DONE:
  - each edge with alu_done=0: tcnt++;
  - alu_done sampled 1: go to RECV, rcnt <= 0;
  - tcnt reaches TIMEOUT_CYCLES-1 without done: go to FAULT.
- RECV: capture alu_out on each of the 4 edges immediately following the edge at which done was sampled. Byte k goes to result[8k+7:8k]. At the 4th capture, register resp_result, set resp_valid <= 1, resp_error <= 0, go to RESP.
- RESP (1 cycle): resp_valid=1, then clear it and go to IDLE. resp_result holds until the next response.
- Nominal latency: with the ALU done visible 12 edges after start is sampled, done is sampled at E13, bytes are captured at E14..E17, and resp_valid is high in the cycle after E17 (17 cycles after acceptance).
- FAULT: pulse resp_valid=1 with resp_error=1 and resp_result=0 for one cycle. Afterwards req_ready stays 0 (the link is desynchronised) until rst_n.
- req_valid outside IDLE is ignored; a request is never dropped, only stalled.
- alu_done seen outside WAIT_DONE is ignored.

Decomposition:
- Shared package fp_alu_pkg holds:
  - state enum;
  - OPERAND_BYTES=4, SEND_BYTES=8, RESULT_BYTES=4;
  - OP_ADD=0, OP_SUB=1.
- No sub-module: the byte mux and shift-in register are inline.
- The bench instantiates the fp_alu_host → ALU pair.

Test Plan:
- A=0x3F800000, B=0x40000000, op=0 → alu_in sequence 00,00,80,3F,00,00,00,40; resp_result=0x40400000, resp_error=0, resp_valid exactly 17 cycles after acceptance.
- A=0x40400000, B=0x3F800000, op=1 → resp_result=0x40000000; alu_opcode stable 1 from E0 until RESP.
- Back-to-back requests held valid (1.0+1.0, then 2.0-0.5) → responses 0x40000000 then 0x3FC00000; req_ready low between accept and RESP exit; no overlap of alu_start.
- alu_done tied 0 (ALU stub) → resp_valid with resp_error=1, resp_result=0 at WAIT_DONE+TIMEOUT_CYCLES; req_ready stays 0 until rst_n pulse, then 1.
- rst_n asserted during SEND cnt=3 → all outputs 0 asynchronously, no resp_valid; a new 1.0+2.0 request after release returns 0x40400000.
- Spurious alu_done pulse while IDLE/SEND (stub) → no state change, no response.
